prog_imem: RTL and testbench

PROG_IMEM -- requirements
Module: prog_imem

---
 rtl/prog_imem_if.sv | 32 +++
 rtl/prog_imem.sv | 190 +++++++++++++++++++
 tb/tb_prog_imem.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/prog_imem_if.sv
// Program instruction memory bus.
// Groups the program-load, clear, fetch request and fetch result signals of
// prog_imem into one bundle.
//   master : drives Load_En/Load_Addr/Load_Data, Clear_Req, Fetch_Req/Read_Address;
//            observes instruction, Instr_Valid, Addr_Err, Load_Err, Busy.
//   slave  : the memory side (prog_imem), the mirror image of master.
interface prog_imem_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              Load_En;
  logic [ADDR_W-1:0] Load_Addr;
  logic [DATA_W-1:0] Load_Data;
  logic              Clear_Req;
  logic              Fetch_Req;
  logic [ADDR_W-1:0] Read_Address;
  logic [DATA_W-1:0] instruction;
  logic              Instr_Valid;
  logic              Addr_Err;
  logic              Load_Err;
  logic              Busy;

  modport master (
    output Load_En, Load_Addr, Load_Data, Clear_Req, Fetch_Req, Read_Address,
    input  instruction, Instr_Valid, Addr_Err, Load_Err, Busy
  );

  modport slave (
    input  Load_En, Load_Addr, Load_Data, Clear_Req, Fetch_Req, Read_Address,
    output instruction, Instr_Valid, Addr_Err, Load_Err, Busy
  );
endinterface

// File: rtl/prog_imem.sv
// Program instruction memory.
// A DEPTH x DATA_W register array that is written by a program-load port,
// swept to FILL_WORD by a clear request (one word per cycle) and read by a
// fetch port with one cycle of latency.
// Ports:
//   clk  : single clock, all state changes on its rising edge
//   rst  : synchronous active-high reset; clears memory, FSM and outputs
//   bus  : prog_imem_if.slave
//          Load_En/Load_Addr/Load_Data  program-load write
//          Clear_Req                    start a sweep of all words to FILL_WORD
//          Fetch_Req/Read_Address       fetch request
//          instruction/Instr_Valid/Addr_Err  registered fetch result
//          Load_Err                     sticky out-of-range load flag
//          Busy                         combinational fetch back-pressure
module prog_imem #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter int                DEPTH     = 32,
  parameter logic [DATA_W-1:0] FILL_WORD = {DATA_W{1'b0}}
) (
  input  logic        clk,
  input  logic        rst,
  prog_imem_if.slave  bus
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH widened by one bit so that DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CNT_W-1:0]    sweep_cnt_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];

  logic                busy_s;
  logic                load_in_range_s;
  logic                fetch_in_range_s;
  logic                load_ok_s;
  logic                load_bad_s;
  logic                clear_start_s;
  logic                clear_wr_s;
  logic                fetch_ok_s;
  logic [CNT_W-1:0]    load_idx_s;
  logic [CNT_W-1:0]    fetch_idx_s;

  logic [DATA_W-1:0]   instruction_r;
  logic                instr_valid_r;
  logic                addr_err_r;
  logic                load_err_r;

  // Only the low CNT_W bits are used to index; the range check guards the rest.
  assign load_idx_s  = bus.Load_Addr[CNT_W-1:0];
  assign fetch_idx_s = bus.Read_Address[CNT_W-1:0];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; a clear request during a sweep does not restart it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.Clear_Req) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (sweep_cnt_r == LAST_IDX) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode: write enables, load error strobe and fetch back-pressure.
  always_comb begin
    busy_s           = 1'b0;
    load_ok_s        = 1'b0;
    load_bad_s       = 1'b0;
    clear_start_s    = 1'b0;
    clear_wr_s       = 1'b0;
    load_in_range_s  = ({1'b0, bus.Load_Addr} < DEPTH_A);
    fetch_in_range_s = ({1'b0, bus.Read_Address} < DEPTH_A);
    case (state_r)
      ST_IDLE: begin
        // A load in the same cycle as a clear request still completes.
        busy_s        = bus.Load_En | bus.Clear_Req;
        load_ok_s     = bus.Load_En & load_in_range_s;
        load_bad_s    = bus.Load_En & ~load_in_range_s;
        clear_start_s = bus.Clear_Req;
      end
      ST_CLEAR: begin
        busy_s     = 1'b1;
        clear_wr_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
    // Busy already covers every write, so an accepted fetch never races a write.
    fetch_ok_s = bus.Fetch_Req & ~busy_s;
  end

  // Sweep counter: zeroed on entry to CLEAR, stepped once per swept word.
  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_cnt_r <= {CNT_W{1'b0}};
    end else if (clear_start_s) begin
      sweep_cnt_r <= {CNT_W{1'b0}};
    end else if (clear_wr_s) begin
      if (sweep_cnt_r == LAST_IDX) begin
        sweep_cnt_r <= {CNT_W{1'b0}};
      end else begin
        sweep_cnt_r <= sweep_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      sweep_cnt_r <= sweep_cnt_r;
    end
  end

  // Storage array: reset fill, sweep write, or program-load write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= FILL_WORD;
      end
    end else if (clear_wr_s) begin
      mem_r[sweep_cnt_r] <= FILL_WORD;
    end else if (load_ok_s) begin
      mem_r[load_idx_s] <= bus.Load_Data;
    end
  end

  // Fetch result registers; instruction holds when no fetch is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      instruction_r <= FILL_WORD;
      instr_valid_r <= 1'b0;
      addr_err_r    <= 1'b0;
    end else if (fetch_ok_s) begin
      instr_valid_r <= 1'b1;
      if (fetch_in_range_s) begin
        instruction_r <= mem_r[fetch_idx_s];
        addr_err_r    <= 1'b0;
      end else begin
        instruction_r <= FILL_WORD;
        addr_err_r    <= 1'b1;
      end
    end else begin
      instruction_r <= instruction_r;
      instr_valid_r <= 1'b0;
      addr_err_r    <= 1'b0;
    end
  end

  // Sticky out-of-range load flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_err_r <= 1'b0;
    end else if (load_bad_s) begin
      load_err_r <= 1'b1;
    end else begin
      load_err_r <= load_err_r;
    end
  end

  assign bus.instruction = instruction_r;
  assign bus.Instr_Valid = instr_valid_r;
  assign bus.Addr_Err    = addr_err_r;
  assign bus.Load_Err    = load_err_r;
  assign bus.Busy        = busy_s;

endmodule

// File: tb/tb_prog_imem.sv
// Self-checking bench for prog_imem (DATA_W=8, ADDR_W=8, DEPTH=32, FILL_WORD=0).
// A reference model tracks memory, sweep state and the sticky load error;
// expected fetch results are queued when a fetch is accepted and compared
// when the DUT presents them one cycle later.
module tb_prog_imem;

  localparam int          DW    = 8;
  localparam int          AW    = 8;
  localparam int          DEPTH = 32;
  localparam logic [7:0]  FILL  = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  prog_imem_if #(.DATA_W(DW), .ADDR_W(AW)) bus_if ();

  prog_imem #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .DEPTH     (DEPTH),
    .FILL_WORD (FILL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct packed {
    logic [7:0] instr;
    logic       err;
  } exp_t;

  exp_t       sb_q [$];
  int         checks = 0;
  int         errors = 0;
  string      phase  = "init";

  logic [7:0] m_mem [DEPTH];
  logic       m_clear = 1'b0;
  int         m_cnt   = 0;
  logic       m_lerr  = 1'b0;
  logic [7:0] m_instr = 8'h00;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", phase, tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check Busy, queue expectation, advance model, check outputs.
  task automatic cycle(input logic r, input logic ld, input logic [7:0] la, input logic [7:0] ldat,
                       input logic clr, input logic fr, input logic [7:0] ra);
    logic exp_busy;
    logic acc;
    exp_t e;
    rst                 = r;
    bus_if.Load_En      = ld;
    bus_if.Load_Addr    = la;
    bus_if.Load_Data    = ldat;
    bus_if.Clear_Req    = clr;
    bus_if.Fetch_Req    = fr;
    bus_if.Read_Address = ra;
    #1;
    exp_busy = m_clear | ld | (clr & ~m_clear);
    acc      = 1'b0;
    if (!r) begin
      check_val("busy", {31'd0, bus_if.Busy}, {31'd0, exp_busy});
      acc = fr & ~exp_busy;
    end
    if (acc) begin
      e.instr = (ra < DEPTH) ? m_mem[ra[4:0]] : FILL;
      e.err   = (ra >= DEPTH);
      sb_q.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = FILL;
      m_clear = 1'b0;
      m_cnt   = 0;
      m_lerr  = 1'b0;
      m_instr = FILL;
    end else if (m_clear) begin
      m_mem[m_cnt] = FILL;
      m_cnt++;
      if (m_cnt == DEPTH) begin
        m_clear = 1'b0;
        m_cnt   = 0;
      end
    end else begin
      if (ld) begin
        if (la < DEPTH) m_mem[la[4:0]] = ldat;
        else            m_lerr = 1'b1;
      end
      if (clr) begin
        m_clear = 1'b1;
        m_cnt   = 0;
      end
    end
    #1;
    if (acc) begin
      e = sb_q.pop_front();
      check_val("instr",    {24'd0, bus_if.instruction}, {24'd0, e.instr});
      check_val("valid",    {31'd0, bus_if.Instr_Valid}, 32'd1);
      check_val("addr_err", {31'd0, bus_if.Addr_Err},    {31'd0, e.err});
      m_instr = e.instr;
    end else begin
      check_val("valid_idle", {31'd0, bus_if.Instr_Valid}, 32'd0);
      check_val("err_idle",   {31'd0, bus_if.Addr_Err},    32'd0);
      check_val("instr_hold", {24'd0, bus_if.instruction}, {24'd0, m_instr});
    end
    check_val("load_err", {31'd0, bus_if.Load_Err}, {31'd0, m_lerr});
  endtask

  task automatic nop();
    cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic ld(input logic [7:0] a, input logic [7:0] d);
    cycle(1'b0, 1'b1, a, d, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic fe(input logic [7:0] a);
    cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, a);
  endtask

  initial begin
    phase = "reset";
    do_reset();
    do_reset();

    phase = "fetch_after_reset";
    fe(8'd5);
    nop();

    phase = "load_fetch";
    ld(8'd0, 8'h69);
    fe(8'd0);
    fe(8'd0);
    fe(8'd1);
    fe(8'd0);
    nop();

    phase = "load_blocks_fetch";
    cycle(1'b0, 1'b1, 8'd3, 8'h5A, 1'b0, 1'b1, 8'd3);
    fe(8'd3);
    nop();

    phase = "out_of_range";
    fe(8'd40);
    nop();
    ld(8'd40, 8'hEE);
    nop();
    nop();
    fe(8'd3);
    ld(8'd32, 8'h01);
    nop();
    do_reset();
    nop();

    phase = "clear_sweep";
    ld(8'd31, 8'hC1);
    ld(8'd12, 8'h44);
    fe(8'd31);
    cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 8'd31);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, (i == 3) || (i == 8), (i == 3) ? 8'd45 : 8'd12, 8'h11, (i == 5), 1'b1, 8'd31);
    end
    fe(8'd31);
    fe(8'd12);
    nop();

    phase = "load_and_clear";
    cycle(1'b0, 1'b1, 8'd2, 8'h77, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < DEPTH; i++) nop();
    fe(8'd2);
    nop();

    phase = "reset_mid_clear";
    ld(8'd20, 8'hA5);
    ld(8'd31, 8'h3C);
    cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 10; i++) nop();
    cycle(1'b1, 1'b1, 8'd7, 8'hFF, 1'b1, 1'b1, 8'd7);
    fe(8'd20);
    fe(8'd31);
    fe(8'd7);
    fe(8'd0);
    nop();

    phase = "random";
    for (int i = 0; i < 200; i++) begin
      int unsigned sel;
      logic [7:0]  a;
      logic [7:0]  d;
      sel = $urandom_range(0, 99);
      a   = 8'($urandom_range(0, 39));
      d   = 8'($urandom_range(0, 255));
      if (sel < 35)       ld(a, d);
      else if (sel < 85)  fe(a);
      else if (sel < 87)  cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, a);
      else if (sel < 89)  cycle(1'b0, 1'b1, a, d, 1'b0, 1'b1, a);
      else                nop();
    end
    for (int i = 0; i < 8; i++) fe(8'(i * 4));
    nop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
